// File: rtl/core_pkg.sv
// Shared encodings for the verycore execute stage: funct3 op selects and FSM states.
package core_pkg;

  localparam int unsigned F3_W = 3;

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } exu_state_t;

endpackage

// File: rtl/iter_shifter.sv
// Iterative shifter: moves the working value by up to SHIFT_STEP bits per cycle
// until the remaining count is exhausted.
module iter_shifter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned CW         = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            left,
  input  logic            arith,
  input  logic [XLEN-1:0] load_value,
  input  logic [CW-1:0]   load_amount,
  output logic [XLEN-1:0] next_value_c,
  output logic            done_c
);

  logic [XLEN-1:0] value;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   step;
  logic            left_q;
  logic            arith_q;

  // Value after this cycle's step; done_c flags the step that empties the count.
  always_comb begin
    step         = (remaining >= CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : remaining;
    next_value_c = value >> step;
    if (left_q) begin
      next_value_c = value << step;
    end else if (arith_q) begin
      next_value_c = $unsigned($signed(value) >>> step);
    end
    done_c = (remaining != '0) && (remaining <= CW'(SHIFT_STEP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value     <= '0;
      remaining <= '0;
      left_q    <= 1'b0;
      arith_q   <= 1'b0;
    end else if (load) begin
      value     <= load_value;
      remaining <= load_amount;
      left_q    <= left;
      arith_q   <= arith;
    end else if (remaining != '0) begin
      value     <= next_value_c;
      remaining <= remaining - step;
    end
  end

endmodule

// File: rtl/exec_alu.sv
// RV32I execute unit: single-cycle ALU/branch ops, multi-cycle shifts, valid/ready
// handshakes on both sides with one registered result per accepted op.
module exec_alu
  import core_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_branch,
  input  logic            mod,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            taken
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = SW + 1;

  exu_state_t      state;
  exu_state_t      state_nxt;
  logic [XLEN-1:0] result_nxt;
  logic            taken_nxt;
  logic [XLEN-1:0] alu_c;
  logic            taken_c;
  logic [XLEN-1:0] sum_c;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            accept;
  logic            is_shift;
  logic [SW-1:0]   shamt;
  logic            sh_load;
  logic [XLEN-1:0] sh_next;
  logic            sh_done;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);

  // Single-cycle results; a shift with zero amount passes a through unchanged.
  always_comb begin
    alu_c    = '0;
    taken_c  = 1'b0;
    sum_c    = mod ? (a - b) : (a + b);
    lt_s     = $signed(a) < $signed(b);
    lt_u     = a < b;
    eq       = (a == b);
    shamt    = b[SW-1:0];
    is_shift = !is_branch && ((funct3 == F3_SLL) || (funct3 == F3_SR));
    if (is_branch) begin
      case (funct3)
        F3_BEQ:  taken_c = eq;
        F3_BNE:  taken_c = !eq;
        F3_BLT:  taken_c = lt_s;
        F3_BGE:  taken_c = !lt_s;
        F3_BLTU: taken_c = lt_u;
        F3_BGEU: taken_c = !lt_u;
        default: taken_c = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_ADD:  alu_c = sum_c;
        F3_SLT:  alu_c = XLEN'(lt_s);
        F3_SLTU: alu_c = XLEN'(lt_u);
        F3_XOR:  alu_c = a ^ b;
        F3_OR:   alu_c = a | b;
        F3_AND:  alu_c = a & b;
        default: alu_c = a;
      endcase
    end
  end

  // Next state and result capture; an accept overrides the current state's default.
  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    taken_nxt  = taken;
    sh_load    = 1'b0;
    accept     = in_valid && in_ready;
    case (state)
      IDLE: state_nxt = IDLE;
      SHIFT: begin
        if (sh_done) begin
          state_nxt  = DONE;
          result_nxt = sh_next;
          taken_nxt  = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      if (is_shift && (shamt != '0)) begin
        state_nxt = SHIFT;
        sh_load   = 1'b1;
      end else begin
        state_nxt  = DONE;
        result_nxt = alu_c;
        taken_nxt  = taken_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      taken  <= 1'b0;
    end else begin
      state  <= state_nxt;
      result <= result_nxt;
      taken  <= taken_nxt;
    end
  end

  iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .CW         (CW)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (sh_load),
    .left         (funct3 == F3_SLL),
    .arith        (mod && (funct3 == F3_SR)),
    .load_value   (a),
    .load_amount  (CW'(shamt)),
    .next_value_c (sh_next),
    .done_c       (sh_done)
  );

endmodule

// File: tb/tb_exec_alu.sv
// Bench for exec_alu: directed vectors, random ops against an arithmetic reference,
// handshake/back-pressure scenarios and reset during a shift (SHIFT_STEP 1 and 4).
module tb_exec_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid4;
  logic        is_branch, mod, out_ready;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        in_ready1, out_valid1, taken1;
  logic [31:0] result1;
  logic        in_ready4, out_valid4, taken4;
  logic [31:0] result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_alu #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .is_branch(is_branch), .mod(mod), .funct3(funct3), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .taken(taken1)
  );

  exec_alu #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .is_branch(is_branch), .mod(mod), .funct3(funct3), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .taken(taken4)
  );

  typedef struct {
    string       name;
    bit          use4;
    bit          br;
    bit          md;
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] er;
    logic        et;
    int          el;
  } vec_t;

  // Reference: {taken, result} computed straight from the instruction semantics.
  function automatic logic [32:0] model(input bit br, input bit md, input logic [2:0] f,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r = '0;
    logic        t = 1'b0;
    int          sh = int'(y & 32'h1f);
    bit          slt = (x[31] != y[31]) ? x[31] : (x < y);
    if (br) begin
      case (f)
        3'd0: t = (x == y);
        3'd1: t = (x != y);
        3'd4: t = slt;
        3'd5: t = !slt;
        3'd6: t = (x < y);
        3'd7: t = (x >= y);
        default: t = 1'b0;
      endcase
    end else begin
      case (f)
        3'd0: r = md ? x - y : x + y;
        3'd1: r = x << sh;
        3'd2: r = slt ? 32'd1 : 32'd0;
        3'd3: r = (x < y) ? 32'd1 : 32'd0;
        3'd4: r = x ^ y;
        3'd5: begin
          r = x >> sh;
          if (md && x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        end
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end
    return {t, r};
  endfunction

  function automatic int exp_lat(input bit br, input logic [2:0] f, input logic [31:0] y,
                                 input int step);
    int sh = int'(y & 32'h1f);
    if (!br && (f == 3'd1 || f == 3'd5)) return 1 + (sh + step - 1) / step;
    return 1;
  endfunction

  task automatic drive(input bit br, input bit md, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    is_branch = br; mod = md; funct3 = f; a = x; b = y;
  endtask

  // Issue one op to an idle unit, return latency and the presented result, then drain it.
  task automatic run_op(input bit use4, input bit br, input bit md, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] res, output logic tk,
                        output bit timeout);
    drive(br, md, f, x, y);
    out_ready = 1'b1;
    if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    drive(~br, ~md, ~f, ~x, ~y);
    lat = 1;
    while (!(use4 ? out_valid4 : out_valid1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    timeout = !(use4 ? out_valid4 : out_valid1);
    res = use4 ? result4 : result1;
    tk  = use4 ? taken4 : taken1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid1 !== 1'b0 || result1 !== 32'd0 || taken1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b result=%h taken=%b, want 0 0 0",
               out_valid1, result1, taken1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%b/%b out_valid=%b, want 1/1 0",
               in_ready1, in_ready4, out_valid1);
    end
  endtask

  task automatic run_table(input vec_t v[$]);
    int lat; logic [31:0] res; logic tk; bit to;
    foreach (v[i]) begin
      run_op(v[i].use4, v[i].br, v[i].md, v[i].f, v[i].x, v[i].y, lat, res, tk, to);
      checks++;
      if (to || lat !== v[i].el || res !== v[i].er || tk !== v[i].et) begin
        errors++;
        $display("FAIL %s: timeout=%0b lat=%0d result=%h taken=%b, want lat=%0d result=%h taken=%b",
                 v[i].name, to, lat, res, tk, v[i].el, v[i].er, v[i].et);
      end
    end
  endtask

  task automatic test_alu_branch;
    vec_t v[$];
    v.push_back('{"add_wrap", 0, 0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,          1'b0, 1});
    v.push_back('{"sub_wrap", 0, 0, 1, 3'd0, 32'd0,         32'd1, 32'hFFFF_FFFF,  1'b0, 1});
    v.push_back('{"slt",      0, 0, 0, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1,          1'b0, 1});
    v.push_back('{"sltu",     0, 0, 0, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0,          1'b0, 1});
    v.push_back('{"blt",      0, 1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0,          1'b1, 1});
    v.push_back('{"bgeu",     0, 1, 0, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd0,          1'b1, 1});
    v.push_back('{"beq",      0, 1, 0, 3'd0, 32'd5,         32'd5, 32'd0,          1'b1, 1});
    v.push_back('{"br_ill",   0, 1, 1, 3'd2, 32'd5,         32'd5, 32'd0,          1'b0, 1});
    run_table(v);
  endtask

  task automatic test_shift;
    vec_t v[$];
    v.push_back('{"sra_1",     0, 0, 1, 3'd5, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 2});
    v.push_back('{"sll_31",    0, 0, 0, 3'd1, 32'd1,         32'd31, 32'h8000_0000, 1'b0, 32});
    v.push_back('{"sll_0",     0, 0, 0, 3'd1, 32'h1234_5678, 32'h40, 32'h1234_5678, 1'b0, 1});
    v.push_back('{"srl_31_s4", 1, 0, 0, 3'd5, 32'h8000_0001, 32'd31, 32'd1,         1'b0, 9});
    v.push_back('{"sra_4_s4",  1, 0, 1, 3'd5, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 2});
    run_table(v);
  endtask

  task automatic test_random;
    int lat; logic [31:0] res; logic tk; bit to;
    logic [32:0] e; int el;
    bit use4, br, md; logic [2:0] f; logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      use4 = (i >= 25);
      br = 1'($urandom_range(0, 1)); md = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7)); x = $urandom; y = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      e  = model(br, md, f, x, y);
      el = exp_lat(br, f, y, use4 ? 4 : 1);
      run_op(use4, br, md, f, x, y, lat, res, tk, to);
      checks++;
      if (to || lat !== el || res !== e[31:0] || tk !== e[32]) begin
        errors++;
        $display("FAIL random_%0d: br=%b f=%0d lat=%0d result=%h taken=%b, want lat=%0d result=%h taken=%b",
                 i, br, f, lat, res, tk, el, e[31:0], e[32]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e; bit br, md; logic [2:0] f; logic [31:0] x, y;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      br = 1'($urandom_range(0, 1)); md = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7)); x = $urandom; y = $urandom;
      if (!br && (f == 3'd1 || f == 3'd5)) f = 3'd4;
      drive(br, md, f, x, y);
      in_valid = 1'b1;
      e = model(br, md, f, x, y);
      checks++;
      if (in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready=%b, want 1", i, in_ready1);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b1 || result1 !== e[31:0] || taken1 !== e[32]) begin
        errors++;
        $display("FAIL b2b_%0d: out_valid=%b result=%h taken=%b, want 1 %h %b",
                 i, out_valid1, result1, taken1, e[31:0], e[32]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid1);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] x, y, x2, y2;
    x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
    drive(1'b0, 1'b0, 3'd0, x, y);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd0, ~x, ~y);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b1 || result1 !== x + y || in_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                 i, out_valid1, result1, in_ready1, x + y);
      end
    end
    drive(1'b0, 1'b0, 3'd4, x2, y2);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: in_ready=%b, want 1", in_ready1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid1 !== 1'b1 || result1 !== (x2 ^ y2)) begin
      errors++;
      $display("FAIL release_xfer: out_valid=%b result=%h, want 1 %h",
               out_valid1, result1, x2 ^ y2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    int lat; logic [31:0] res; logic tk; bit to; logic [31:0] x, y;
    drive(1'b0, 1'b0, 3'd1, 32'd1, 32'd31);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL midshift_busy: out_valid=%b, want 0", out_valid1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid1 !== 1'b0 || result1 !== 32'd0 || taken1 !== 1'b0) begin
      errors++;
      $display("FAIL midshift_reset: out_valid=%b result=%h taken=%b, want 0 0 0",
               out_valid1, result1, taken1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL midshift_ghost: out_valid=%b after reset, want 0", out_valid1);
      end
    end
    x = $urandom; y = $urandom;
    run_op(1'b0, 1'b0, 1'b0, 3'd0, x, y, lat, res, tk, to);
    checks++;
    if (to || lat !== 1 || res !== x + y) begin
      errors++;
      $display("FAIL post_reset_add: lat=%0d result=%h, want 1 %h", lat, res, x + y);
    end
  endtask

  initial begin
    test_reset;
    test_alu_branch;
    test_shift;
    test_random;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
